// File: rtl/swt_pkg.sv
// Shared constants for the slide-switch input conditioner.
// Synthesis uses the 10 ms debounce window; benches use the short one.
package swt_pkg;

  localparam int NUM_SWT_DEF         = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  // The counter must be able to hold DEBOUNCE_CYCLES-1 without wrapping.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/swt_debounce_if.sv
// Event-mask handshake between the switch conditioner and its consumer.
interface swt_debounce_if #(
  parameter int NUM_SWT = 8
);

  logic [NUM_SWT-1:0] evt_mask;
  logic               evt_valid;
  logic               evt_ack;

  modport master (
    output evt_mask,
    output evt_valid,
    input  evt_ack
  );

  modport slave (
    input  evt_mask,
    input  evt_valid,
    output evt_ack
  );

endinterface

// File: rtl/swt_debounce_bit.sv
// One switch lane: two-flop synchroniser, stability counter, clean level
// and registered rise/fall pulses that follow a clean-level change.
module swt_debounce_bit
  import swt_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int   CNT_W           = cnt_width(DEBOUNCE_CYCLES),
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             clean_prev;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ = (sync2 != clean);
  assign accept = differ && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Any return to the clean level throws away all accumulated stability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      clean <= RESET_VAL;
    end else begin
      if (!differ || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (accept) begin
        clean <= sync2;
      end
    end
  end

  // Pulses are derived from the clean level itself, so they land one
  // cycle after the clean output moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_prev <= RESET_VAL;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      clean_prev <= clean;
      rise       <= clean & ~clean_prev;
      fall       <= ~clean & clean_prev;
    end
  end

endmodule

// File: rtl/swt_debounce.sv
// Slide-switch conditioner: per-bit debounce lanes plus a sticky change
// mask that a downstream consumer drains with valid/ack.
module swt_debounce
  import swt_pkg::*;
#(
  parameter int                 NUM_SWT         = NUM_SWT_DEF,
  parameter int                 DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int                 CNT_W           = cnt_width(DEBOUNCE_CYCLES),
  parameter logic [NUM_SWT-1:0] RESET_VAL       = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SWT-1:0] swt,
  output logic [NUM_SWT-1:0] swt_clean,
  output logic [NUM_SWT-1:0] swt_rise,
  output logic [NUM_SWT-1:0] swt_fall,
  swt_debounce_if.master     evt
);

  logic [NUM_SWT-1:0] chg;
  logic [NUM_SWT-1:0] mask;
  logic               valid;

  for (genvar i = 0; i < NUM_SWT; i++) begin : g_lane
    swt_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_VAL       (RESET_VAL[i])
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (swt[i]),
      .clean (swt_clean[i]),
      .rise  (swt_rise[i]),
      .fall  (swt_fall[i])
    );
  end

  assign chg   = swt_rise | swt_fall;
  assign valid = |mask;

  // An accepted ack clears the old bits but keeps whatever changed this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (valid && evt.evt_ack) begin
      mask <= chg;
    end else begin
      mask <= mask | chg;
    end
  end

  assign evt.evt_mask  = mask;
  assign evt.evt_valid = valid;

endmodule

// File: tb/tb_swt_debounce.sv
// Self-checking bench for swt_debounce using a sample-history reference
// model: a level is accepted once it has differed for a full window.
module tb_swt_debounce;
  import swt_pkg::*;

  localparam int         N   = 8;
  localparam int         DEB = DEBOUNCE_CYCLES_SIM;
  localparam logic [7:0] RV  = 8'h00;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] swt   = 8'h00;
  logic [7:0] swt_clean;
  logic [7:0] swt_rise;
  logic [7:0] swt_fall;

  swt_debounce_if #(.NUM_SWT(N)) evt_if ();

  swt_debounce #(
    .NUM_SWT         (N),
    .DEBOUNCE_CYCLES (DEB),
    .RESET_VAL       (RV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .swt       (swt),
    .swt_clean (swt_clean),
    .swt_rise  (swt_rise),
    .swt_fall  (swt_fall),
    .evt       (evt_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: a log of every sampled switch word since reset.
  logic [7:0] samp[$];
  logic [7:0] m_clean = RV;
  logic [7:0] m_rise  = '0;
  logic [7:0] m_fall  = '0;
  logic [7:0] m_mask  = '0;
  logic [7:0] m_up    = '0;
  logic [7:0] m_dn    = '0;
  logic [7:0] m_next;
  logic [7:0] m_v;
  logic       m_all;
  int         m_n;

  function automatic logic [7:0] sample_at(input int k);
    if (k < 1) return RV;
    return samp[k-1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp.delete();
      m_clean = RV;
      m_rise  = '0;
      m_fall  = '0;
      m_mask  = '0;
      m_up    = '0;
      m_dn    = '0;
    end else begin
      if ((|m_mask) && evt_if.evt_ack) m_mask = m_rise | m_fall;
      else                             m_mask = m_mask | m_rise | m_fall;
      m_rise = m_up;
      m_fall = m_dn;
      samp.push_back(swt);
      m_n    = samp.size();
      m_next = m_clean;
      for (int i = 0; i < N; i++) begin
        m_all = 1'b1;
        for (int d = 2; d <= DEB + 1; d++) begin
          m_v = sample_at(m_n - d);
          if (m_v[i] == m_clean[i]) m_all = 1'b0;
        end
        if (m_all) m_next[i] = ~m_clean[i];
      end
      m_up    = m_next & ~m_clean;
      m_dn    = ~m_next & m_clean;
      m_clean = m_next;
    end
  end

  wire [32:0] dut_vec = {swt_clean, swt_rise, swt_fall, evt_if.evt_mask, evt_if.evt_valid};
  wire [32:0] mdl_vec = {m_clean, m_rise, m_fall, m_mask, |m_mask};

  task automatic do_ack();
    evt_if.evt_ack = 1'b1;
    @(negedge clk);
    evt_if.evt_ack = 1'b0;
  endtask

  task automatic test_reset();
    evt_if.evt_ack = 1'b0;
    rst_n = 1'b0;
    swt   = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec !== 33'd0) begin
      failures++;
      $display("[TB] FAIL reset_hold: got %h expected %h", dut_vec, 33'd0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        failures++;
        $display("[TB] FAIL reset_release_model edge %0d: got %h expected %h", e, dut_vec, mdl_vec);
      end
      if (e == 5) begin
        checks++;
        if (swt_clean !== 8'h00) begin
          failures++;
          $display("[TB] FAIL reset_clean_early: got %h expected 00", swt_clean);
        end
      end
      if (e == 6) begin
        checks++;
        if ({swt_clean, swt_rise} !== {8'hFF, 8'h00}) begin
          failures++;
          $display("[TB] FAIL reset_clean_edge6: got %h expected ff00", {swt_clean, swt_rise});
        end
      end
      if (e == 7) begin
        checks++;
        if (swt_rise !== 8'hFF) begin
          failures++;
          $display("[TB] FAIL reset_rise_edge7: got %h expected ff", swt_rise);
        end
      end
      if (e == 8) begin
        checks++;
        if ({swt_rise, evt_if.evt_mask, evt_if.evt_valid} !== {8'h00, 8'hFF, 1'b1}) begin
          failures++;
          $display("[TB] FAIL reset_mask_edge8: got %h expected 00ff1",
                   {swt_rise, evt_if.evt_mask, evt_if.evt_valid});
        end
      end
    end
  endtask

  task automatic test_bounce();
    int rises = 0;
    swt = 8'hFB;
    repeat (10) @(negedge clk);
    do_ack();
    checks++;
    if (evt_if.evt_mask !== 8'h00) begin
      failures++;
      $display("[TB] FAIL bounce_setup_mask: got %h expected 00", evt_if.evt_mask);
    end
    for (int k = 0; k < 8; k++) begin
      swt[2] = ((k / 2) % 2) == 0;
      @(negedge clk);
      if (swt_rise[2]) rises++;
      checks++;
      if (dut_vec !== mdl_vec || swt_clean[2] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bounce_hold step %0d: got %h expected %h", k, dut_vec, mdl_vec);
      end
    end
    swt[2] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (swt_rise[2]) rises++;
      checks++;
      if (dut_vec !== mdl_vec) begin
        failures++;
        $display("[TB] FAIL bounce_settle step %0d: got %h expected %h", k, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (rises != 1 || swt_clean[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bounce_single_rise: got rises=%0d clean=%b expected rises=1 clean=1",
               rises, swt_clean[2]);
    end
  endtask

  task automatic test_collision();
    bit found = 0;
    do_ack();
    swt = 8'hFE;
    repeat (2) @(negedge clk);
    swt = 8'hDE;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (swt_fall[5]) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL collision_wait: got no fall[5] expected a pulse within 20 cycles");
    end else begin
      checks++;
      if (evt_if.evt_mask !== 8'h01) begin
        failures++;
        $display("[TB] FAIL collision_pre_mask: got %h expected 01", evt_if.evt_mask);
      end
      do_ack();
      checks++;
      if ({evt_if.evt_mask, evt_if.evt_valid} !== {8'h20, 1'b1} || dut_vec !== mdl_vec) begin
        failures++;
        $display("[TB] FAIL collision_post_mask: got %h/%b expected 20/1",
                 evt_if.evt_mask, evt_if.evt_valid);
      end
    end
  endtask

  task automatic test_spurious_ack();
    do_ack();
    checks++;
    if (evt_if.evt_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL spurious_setup: got valid=%b expected 0", evt_if.evt_valid);
    end
    evt_if.evt_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({evt_if.evt_mask, evt_if.evt_valid} !== 9'd0 || dut_vec !== mdl_vec) begin
        failures++;
        $display("[TB] FAIL spurious_ack cycle %0d: got %h expected %h", k, dut_vec, mdl_vec);
      end
    end
    evt_if.evt_ack = 1'b0;
  endtask

  task automatic test_multi_toggle();
    int rises = 0;
    int falls = 0;
    swt[7] = 1'b0;
    repeat (10) @(negedge clk);
    do_ack();
    swt[7] = 1'b1;
    for (int k = 0; k < 22; k++) begin
      if (k == 10) swt[7] = 1'b0;
      @(negedge clk);
      if (swt_rise[7]) rises++;
      if (swt_fall[7]) falls++;
      checks++;
      if (dut_vec !== mdl_vec) begin
        failures++;
        $display("[TB] FAIL multi_toggle_model step %0d: got %h expected %h", k, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (rises != 1 || falls != 1 || evt_if.evt_mask !== 8'h80 || evt_if.evt_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL multi_toggle_sticky: got rises=%0d falls=%0d mask=%h expected 1 1 80",
               rises, falls, evt_if.evt_mask);
    end
    do_ack();
    checks++;
    if ({evt_if.evt_mask, evt_if.evt_valid} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL multi_toggle_ack: got %h/%b expected 00/0",
               evt_if.evt_mask, evt_if.evt_valid);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int k = 0; k < 400; k++) begin
      if (hold == 0) begin
        swt  = swt ^ 8'($urandom & $urandom);
        hold = $urandom_range(1, 10);
      end
      hold--;
      evt_if.evt_ack = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec || (swt_rise & swt_fall) !== 8'h00) begin
        failures++;
        $display("[TB] FAIL random step %0d: got %h expected %h", k, dut_vec, mdl_vec);
      end
    end
    evt_if.evt_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    swt = 8'h00;
    repeat (12) @(negedge clk);
    swt = 8'h0F;
    repeat (10) @(negedge clk);
    swt = 8'hF0;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (swt_clean !== 8'h0F || evt_if.evt_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_pre: got clean=%h valid=%b expected 0f 1",
               swt_clean, evt_if.evt_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 33'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_async: got %h expected 0", dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        failures++;
        $display("[TB] FAIL reset_mid_model edge %0d: got %h expected %h", e, dut_vec, mdl_vec);
      end
      if (e == 5 || e == 6) begin
        checks++;
        if (swt_clean !== ((e == 6) ? 8'hF0 : 8'h00)) begin
          failures++;
          $display("[TB] FAIL reset_mid_recover edge %0d: got %h expected %h",
                   e, swt_clean, (e == 6) ? 8'hF0 : 8'h00);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_collision();
    test_spurious_ack();
    test_multi_toggle();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swt_debounce.md
Name: swt_debounce

Overview:
- Input conditioner for the board slide switches. It is the input-side counterpart to the switch-to-LED display logic.
- It synchronises the eight raw switch inputs into the clock domain and debounces each one independently.
- It drives a clean level for each switch, plus one-cycle rise and fall pulses.
- It accumulates switch changes into a sticky event mask, which a downstream consumer (LED/control logic) drains with a valid/ack handshake.

Parameters:
- NUM_SWT, 8, number of switch inputs handled.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed before a new level is accepted (10 ms at 100 MHz). Must be ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each per-bit stability counter.
- RESET_VAL, 8'h00, reset value of the synchroniser flops and of swt_clean.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- swt  input  NUM_SWT  raw asynchronous switch levels.
- swt_clean  output  NUM_SWT  debounced switch levels.
- swt_rise  output  NUM_SWT  one-cycle pulse when a swt_clean bit goes 0→1.
- swt_fall  output  NUM_SWT  one-cycle pulse when a swt_clean bit goes 1→0.
- evt_valid  output  1  high while any bit of evt_mask is set.
- evt_mask  output  NUM_SWT  sticky record of bits that changed since the last accepted ack.
- evt_ack  input  1  consumer acknowledge; acts only when evt_valid=1.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low on rst_n; one clock, clk.
  - While rst_n=0: sync1/sync2=RESET_VAL, swt_clean=RESET_VAL, counters=0, swt_rise=0, swt_fall=0, evt_mask=0, evt_valid=0.
  - Deassertion of rst_n is assumed to be synchronised externally.
- Synchroniser: a 2-flop chain per bit (sync1←swt, sync2←sync1). Only sync2 feeds the debounce logic.
- Per-bit debounce, evaluated every clk edge:
  - If sync2 == swt_clean: counter ← 0.
  - Else, if counter == DEBOUNCE_CYCLES-1: swt_clean ← sync2 and counter ← 0.
  - Else: counter ← counter+1.
  - Any bounce back to the clean level before acceptance resets the counter to 0. There is no partial credit.
- Latency: after swt settles, the first edge that samples the new value counts as edge 1. swt_clean updates at edge DEBOUNCE_CYCLES+2.
- Edge pulses:
  - swt_rise[i] and swt_fall[i] are registered and assert in the cycle immediately after swt_clean[i] changes, for exactly one cycle.
  - They are never both high for the same bit.
- Event mask: define chg = swt_rise | swt_fall.
  - If evt_valid & evt_ack: evt_mask ← chg. Acked bits clear; a change arriving in the same cycle is retained, never lost.
  - Else: evt_mask ← evt_mask | chg.
  - evt_ack while evt_valid=0 is ignored.
  - evt_valid = |evt_mask, driven combinationally from the evt_mask register.
- Simultaneous changes on several bits are independent and are merged in evt_mask.
- A bit toggling twice between acks stays set; evt_mask does not count changes.
- Counters never wrap: the maximum value held is DEBOUNCE_CYCLES-1.
- Reset asserted mid-debounce discards all counter progress and any pending events.

Decomposition:
- Shared package swt_pkg:
  - NUM_SWT default constant.
  - DEBOUNCE_CYCLES default for synthesis and DEBOUNCE_CYCLES_SIM = 4 for benches.
  - Function for CNT_W.
- Sub-module swt_debounce_bit, instantiated NUM_SWT times through a generate loop:
  - Contents: synchroniser, counter, clean flop, rise/fall flops.
  - Ports: clk, rst_n, din, clean, rise, fall.
  - Parameters: DEBOUNCE_CYCLES, CNT_W, RESET_VAL bit.
- The top level holds only the event-mask register and the handshake.

Test Plan (DEBOUNCE_CYCLES=4, RESET_VAL=0):
- Reset: hold rst_n=0 with swt=8'hFF → all outputs 0. Release and keep swt=8'hFF → swt_clean=8'hFF at edge 6, swt_rise=8'hFF for one cycle at edge 7, evt_mask=8'hFF, evt_valid=1.
- Bounce: swt[2] toggles 1,0,1,0 with each level held 2 cycles, then held at 1 → no change until 4 stable cycles after synchronisation, then swt_clean[2]=1 with a single swt_rise[2] pulse.
- Handshake collision: evt_mask=8'h01; swt_fall[5] pulses in the same cycle that evt_ack=1 → next cycle evt_mask=8'h20, evt_valid=1.
- Spurious ack: evt_ack=1 with evt_valid=0 for 10 cycles → evt_mask stays 0, no other effect.
- Multi-toggle: bit 7 rises, then falls, with no ack in between → evt_mask[7]=1, exactly one rise and one fall pulse. One ack → evt_mask=0, evt_valid=0.
- Reset mid-operation: assert rst_n=0 asynchronously when counter=3 with events pending → immediately all outputs 0. After release with swt stable, swt_clean recovers after DEBOUNCE_CYCLES+2 edges.
